// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: opcodes, load/store funct3 codes and the
// memory-stage FSM state type. Imported by the pipeline stages and registers.
package riscv_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Memory-stage handshake FSM
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2,
    StDone = 2'd3
  } mem_state_e;

endpackage

// File: rtl/lsu_align.sv
// Load/store lane alignment, purely combinational.
// Store side: byte enables, lane-replicated write data and misalignment flag,
//   from the live funct3 and effective address low bits.
// Load side: lane extraction and sign/zero extension of a returned data word,
//   from the funct3 and address low bits captured when the access started.
// Ports:
//   funct3, addr_lo, store_data  -> be, wdata, misaligned
//   ld_funct3, ld_lane, rdata    -> ld_data
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Access size lives in funct3[1:0] for both loads and stores.
  always_comb begin
    be         = 4'b1111;
    wdata      = store_data;
    misaligned = 1'b0;
    case (funct3[1:0])
      F3_SB[1:0]: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_SH[1:0]: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      F3_SW[1:0]: misaligned = (addr_lo != 2'b00);
      default:    misaligned = (addr_lo != 2'b00);
    endcase
  end

  assign shifted = rdata >> {ld_lane, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = shifted[15:0];

  always_comb begin
    ld_data = rdata;
    case (ld_funct3)
      F3_LB:   ld_data = {{24{byte_v[7]}}, byte_v};
      F3_LH:   ld_data = {{16{half_v[15]}}, half_v};
      F3_LBU:  ld_data = {24'h0, byte_v};
      F3_LHU:  ld_data = {16'h0, half_v};
      F3_LW:   ld_data = rdata;
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage between EX/MEM and MEM/WB. Decodes load/store/jump,
// runs a req/gnt/rvalid handshake to data memory, aligns store data, extracts
// load data, and stalls the pipeline while an access is outstanding.
// Ports:
//   clk, reset (async, active-high)
//   instr_in, pc_in, alu_result_in, rs2_in, regwen_in, valid_in  from EX/MEM
//   instr_out, wb_data_out, regwen_out                           to MEM/WB
//   stall_out, misalign_out                                      pipeline control
//   dmem_req/we/addr/wdata/be out, dmem_gnt/rvalid/rdata in      data memory
module mem_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_in,
  input  logic        regwen_in,
  input  logic        valid_in,
  output logic [31:0] instr_out,
  output logic [31:0] wb_data_out,
  output logic        regwen_out,
  output logic        stall_out,
  output logic        misalign_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, is_jump, is_mem;
  logic        misaligned, bad_access, mem_go;
  logic [31:0] load_ext;

  mem_state_e  state_q, state_d;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic [31:0] load_buf_q;
  logic        req, stall, capture;

  assign opcode   = instr_in[6:0];
  assign funct3   = instr_in[14:12];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign is_jump  = (opcode == OPC_JAL) || (opcode == OPC_JALR);
  assign is_mem   = is_load || is_store;

  lsu_align u_lsu_align (
    .funct3     (funct3),
    .addr_lo    (alu_result_in[1:0]),
    .store_data (rs2_in),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .misaligned (misaligned),
    .ld_funct3  (funct3_q),
    .ld_lane    (lane_q),
    .rdata      (dmem_rdata),
    .ld_data    (load_ext)
  );

  assign bad_access = valid_in && is_mem && misaligned;
  assign mem_go     = valid_in && is_mem && !misaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_go) begin
          req     = 1'b1;
          stall   = 1'b1;
          capture = 1'b1;
          if (dmem_gnt) state_d = is_load ? StResp : StDone;
          else          state_d = StReq;
        end
      end
      StReq: begin
        // Upstream holds the instruction, so is_load is still valid here.
        req   = 1'b1;
        stall = 1'b1;
        if (dmem_gnt) state_d = is_load ? StResp : StDone;
      end
      StResp: begin
        stall = 1'b1;
        if (dmem_rvalid) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Only the lane and funct3 are latched; the rest of the access comes from
  // the stalled EX/MEM register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q     <= 2'b00;
      funct3_q   <= 3'b000;
      load_buf_q <= 32'h0;
    end else begin
      if (capture) begin
        lane_q   <= alu_result_in[1:0];
        funct3_q <= funct3;
      end
      if (state_q == StResp && dmem_rvalid) begin
        load_buf_q <= load_ext;
      end
    end
  end

  // Control outputs forced low while reset is held so an abandoned access
  // cannot re-issue or write back before reset is released.
  assign dmem_req     = req && !reset;
  assign stall_out    = stall && !reset;
  assign misalign_out = bad_access && (state_q == StIdle) && !reset;
  assign regwen_out   = regwen_in && valid_in && !is_store && !bad_access && !reset;

  assign dmem_we   = is_store;
  assign dmem_addr = {alu_result_in[31:2], 2'b00};
  assign instr_out = instr_in;

  always_comb begin
    wb_data_out = alu_result_in;
    if (is_jump)      wb_data_out = pc_in + 32'd4;
    else if (is_load) wb_data_out = load_buf_q;
  end

endmodule
